// File: rtl/sample_stream_gen.sv
// sample_stream_gen
//   Periodic 8-bit test-signal generator. A programmable divider produces one
//   sample tick every period+1 enabled cycles. On each tick the output sample
//   advances according to the selected waveform:
//     0 ramp     : x += step (wrapping)
//     1 square   : 0x00/0xFF level, toggled every step+1 samples
//     2 triangle : up/down by step, clamped to 0xFF / 0x00 at the turning points
//     3 noise    : 8-bit maximal-length LFSR
//   The sample and its strobe are registered, so downstream logic (for example
//   an averaging filter) can use x_valid directly as its input-valid.
//
// Ports
//   CLOCK_50 : system clock; all state changes on its rising edge
//   rst_n    : asynchronous active-low reset
//   en       : generator enable (low freezes all waveform state)
//   mode     : waveform select, see above
//   period   : clock cycles between samples minus 1 (read live)
//   step     : ramp/triangle increment; square half-period in samples minus 1
//   x        : current sample (registered)
//   x_valid  : one-cycle strobe, high in the cycle x takes a new sample
module sample_stream_gen (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] period,
  input  logic [7:0] step,
  output logic [7:0] x,
  output logic       x_valid
);

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_NOISE  = 2'd3
  } mode_e;

  typedef enum logic {
    TRI_UP   = 1'b0,
    TRI_DOWN = 1'b1
  } tri_e;

  logic [7:0] r_cnt;
  logic [7:0] r_x;
  logic       r_x_valid;
  logic [7:0] r_sq_cnt;
  logic       r_sq_lvl;
  logic [7:0] r_lfsr;
  tri_e       r_tri;
  mode_e      r_last_mode;

  logic       w_tick;
  mode_e      w_mode;
  logic       w_mode_chg;
  tri_e       w_tri_eff;
  logic [7:0] w_sq_cnt_eff;
  logic       w_sq_lvl_eff;
  logic [8:0] w_sum9;
  logic [7:0] w_lfsr_src;
  logic [7:0] w_lfsr_next;

  // The divider compares against the live period input; if period drops
  // below the running count, the count simply runs through 255 and wraps.
  assign w_tick     = en && (r_cnt == period);
  assign w_mode     = mode_e'(mode);
  assign w_mode_chg = (w_mode != r_last_mode);

  // A mode switch restarts the square and triangle sequences from a known
  // point; these "effective" values are what the current tick operates on.
  assign w_tri_eff    = w_mode_chg ? TRI_UP : r_tri;
  assign w_sq_cnt_eff = w_mode_chg ? 8'h00  : r_sq_cnt;
  assign w_sq_lvl_eff = w_mode_chg ? 1'b0   : r_sq_lvl;

  // 9-bit sum so the triangle peak test sees carries instead of wrapping.
  assign w_sum9 = {1'b0, r_x} + {1'b0, step};

  // Never shift out of the all-zero lock-up state.
  assign w_lfsr_src  = (r_lfsr == 8'h00) ? 8'h01 : r_lfsr;
  assign w_lfsr_next = {w_lfsr_src[6:0],
                        w_lfsr_src[7] ^ w_lfsr_src[5] ^ w_lfsr_src[4] ^ w_lfsr_src[3]};

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_x         <= '0;
      r_x_valid   <= 1'b0;
      r_sq_cnt    <= '0;
      r_sq_lvl    <= 1'b0;
      r_lfsr      <= 8'h01;
      r_tri       <= TRI_UP;
      r_last_mode <= MODE_RAMP;
    end else begin
      r_x_valid <= w_tick;

      if (r_lfsr == 8'h00) begin
        r_lfsr <= 8'h01;
      end

      if (!en) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt       <= '0;
        r_last_mode <= w_mode;
        r_tri       <= w_tri_eff;
        r_sq_cnt    <= w_sq_cnt_eff;
        r_sq_lvl    <= w_sq_lvl_eff;

        unique case (w_mode)
          MODE_RAMP: begin
            r_x <= r_x + step;
          end

          MODE_SQUARE: begin
            if (w_sq_cnt_eff == step) begin
              r_sq_lvl <= ~w_sq_lvl_eff;
              r_sq_cnt <= '0;
              r_x      <= {8{~w_sq_lvl_eff}};
            end else begin
              r_sq_cnt <= w_sq_cnt_eff + 8'd1;
              r_x      <= {8{w_sq_lvl_eff}};
            end
          end

          MODE_TRI: begin
            unique case (w_tri_eff)
              TRI_UP: begin
                if (w_sum9 >= 9'd255) begin
                  r_x   <= 8'hFF;
                  r_tri <= TRI_DOWN;
                end else begin
                  r_x <= w_sum9[7:0];
                end
              end
              TRI_DOWN: begin
                if (r_x <= step) begin
                  r_x   <= '0;
                  r_tri <= TRI_UP;
                end else begin
                  r_x <= r_x - step;
                end
              end
            endcase
          end

          MODE_NOISE: begin
            r_lfsr <= w_lfsr_next;
            r_x    <= w_lfsr_next;
          end
        endcase
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;

endmodule

// File: tb/tb_sample_stream_gen.sv
// tb_sample_stream_gen
//   Scoreboard bench for sample_stream_gen. Stimulus pushes expected samples
//   (value plus expected cycle spacing from the previous strobe) into a queue;
//   a monitor on the falling clock edge pops and compares on every x_valid.
module tb_sample_stream_gen;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b1;
  logic       en       = 1'b0;
  logic [1:0] mode     = 2'd0;
  logic [7:0] period   = 8'd0;
  logic [7:0] step     = 8'd0;
  logic [7:0] x;
  logic       x_valid;

  sample_stream_gen dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .period   (period),
    .step     (step),
    .x        (x),
    .x_valid  (x_valid)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0]  val;
    int unsigned gap;   // 0 = spacing not checked
  } exp_t;

  exp_t        q[$];
  logic [7:0]  cap[$];
  bit          capture  = 1'b0;
  int          total    = 0;
  int          bad      = 0;
  int unsigned cyc      = 0;
  int unsigned last_cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic push(input logic [7:0] v, input int unsigned g);
    exp_t e;
    e.val = v;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic tick_cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_x", {24'd0, x}, 32'h00);
    check("rst_valid", {31'd0, x_valid}, 32'd0);
    @(posedge CLOCK_50);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    tick_cycles(2);
    check("drain_queue_empty", q.size(), 0);
    q.delete();
  endtask

  // Monitor
  always @(negedge CLOCK_50) begin
    exp_t e;
    cyc++;
    if (rst_n && x_valid) begin
      if (capture) cap.push_back(x);
      if (q.size() == 0) begin
        check("unexpected_strobe", {24'd0, x}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("sample_x", {24'd0, x}, {24'd0, e.val});
        if (e.gap != 0) check("strobe_spacing", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] m;
    logic [7:0] tri_tab [7];
    logic [7:0] sq_tab  [8];
    logic [7:0] nz_tab  [4];
    bit         seen    [256];
    int         ndist;

    tri_tab = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
    sq_tab  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    nz_tab  = '{8'h02, 8'h04, 8'h08, 8'h11};

    // Ramp, period 0, step 1: every cycle, 01..FF,00,01
    mode = 2'd0; period = 8'd0; step = 8'd1;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      m = i[7:0];
      push(m, (i == 1) ? 0 : 1);
    end
    tick_cycles(257);
    en = 1'b0;
    drain();

    // Ramp, period 3, step 5: one strobe in four, then hold while disabled
    mode = 2'd0; period = 8'd3; step = 8'd5;
    do_reset();
    en = 1'b1;
    push(8'h05, 0); push(8'h0A, 4); push(8'h0F, 4);
    tick_cycles(12);
    en = 1'b0;
    tick_cycles(10);
    check("hold_x", {24'd0, x}, 32'h0F);
    check("hold_valid", {31'd0, x_valid}, 32'd0);
    drain();

    // Triangle, period 0, step 100
    mode = 2'd2; period = 8'd0; step = 8'd100;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) push(tri_tab[i], (i == 0) ? 0 : 1);
    tick_cycles(7);
    en = 1'b0;
    drain();

    // Noise: 255 samples, distinct, nonzero, last one is 0x01
    mode = 2'd3; period = 8'd0; step = 8'd0;
    do_reset();
    cap.delete();
    capture = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push(nz_tab[i], (i == 0) ? 0 : 1);
    m = 8'h11;
    for (int i = 4; i < 255; i++) begin
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      push(m, 1);
    end
    tick_cycles(255);
    en = 1'b0;
    drain();
    capture = 1'b0;
    check("noise_count", cap.size(), 255);
    foreach (seen[i]) seen[i] = 1'b0;
    ndist = 0;
    foreach (cap[i]) begin
      if (cap[i] != 8'h00 && !seen[cap[i]]) ndist++;
      seen[cap[i]] = 1'b1;
    end
    check("noise_distinct_nonzero", ndist, 255);
    if (cap.size() == 255) check("noise_sample255", {24'd0, cap[254]}, 32'h01);

    // Square step 2, then ramp, back to square, then step 0 toggling
    mode = 2'd1; period = 8'd0; step = 8'd2;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) push(sq_tab[i], (i == 0) ? 0 : 1);
    tick_cycles(8);
    mode = 2'd0;
    push(8'h02, 1); push(8'h04, 1); push(8'h06, 1);
    tick_cycles(3);
    mode = 2'd1;
    push(8'h00, 1); push(8'h00, 1); push(8'hFF, 1);
    tick_cycles(3);
    step = 8'd0;
    push(8'h00, 1); push(8'hFF, 1); push(8'h00, 1);
    tick_cycles(3);
    en = 1'b0;
    drain();

    // Asynchronous reset mid-triangle (x=155, falling), then restart
    mode = 2'd2; period = 8'd0; step = 8'd100;
    do_reset();
    en = 1'b1;
    push(8'd100, 0); push(8'd200, 1); push(8'd255, 1); push(8'd155, 1);
    tick_cycles(4);
    @(negedge CLOCK_50);
    #1 rst_n = 1'b0;
    period = 8'd3;
    #1;
    check("async_rst_x", {24'd0, x}, 32'h00);
    check("async_rst_valid", {31'd0, x_valid}, 32'd0);
    @(posedge CLOCK_50);
    #1 rst_n = 1'b1;
    push(8'd100, 0);
    tick_cycles(3);
    check("post_rst_no_early_tick", {31'd0, x_valid}, 32'd0);
    check("post_rst_x_held", {24'd0, x}, 32'h00);
    tick_cycles(1);
    check("post_rst_first_tick", {31'd0, x_valid}, 32'd1);
    push(8'd200, 4);
    tick_cycles(4);
    en = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
